// File: rtl/wb_dual_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_dual_arbiter
// Description : Two-master / one-slave Wishbone arbiter with round-robin
//               tie-breaking and a slave-response watchdog.
//
//   m0_* (instruction master) and m1_* (data master) each present
//   addr/data/we/sel/stb/cyc and receive data_o/ack_o.  The granted
//   master's request is muxed onto s_* combinationally from the registered
//   grant; s_data_i/s_ack_i are returned only to the granted master.
//   gnt_o shows the current grant (00 idle, 01 m0, 10 m1).  timeout_o
//   pulses for one cycle when the watchdog terminates a stalled cycle,
//   returning BUS_ERR_DATA with a forced ack.
//
//   TIMEOUT      : wait cycles without s_ack_i before forced termination
//                  (1..255).
//   BUS_ERR_DATA : read data returned on forced termination.
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dual_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    // instruction master
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    // data master
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    // shared slave
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    // status
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last;        // master most recently released (0 = m0)
    logic        w_last_nxt;
    logic        w_arb_last;    // "last" as seen by this cycle's arbitration
    logic        w_rearb;
    logic [7:0]  r_wcnt;
    logic [7:0]  w_wcnt_nxt;

    logic        w_g0;
    logic        w_g1;
    logic        w_sel_stb;
    logic        w_timeout;

    // All outputs derive from the registered state, so the asynchronous
    // reset forcing IDLE drives every output to zero immediately.
    assign w_g0      = (r_state == ST_GRANT0);
    assign w_g1      = (r_state == ST_GRANT1);
    assign w_sel_stb = (w_g0 & m0_stb_i) | (w_g1 & m1_stb_i);

    // A real ack in the terminal cycle takes precedence over the watchdog.
    assign w_timeout = w_sel_stb & (r_wcnt == c_timeout) & ~s_ack_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b0;
            r_wcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: a release re-arbitrates in the same cycle with the
    // releasing master treated as "last", so there is no dead cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_arb_last  = r_last;
        w_rearb     = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                if (!m0_cyc_i) begin
                    w_rearb    = 1'b1;
                    w_arb_last = 1'b0;
                    w_last_nxt = 1'b0;
                end
            end
            ST_GRANT1: begin
                if (!m1_cyc_i) begin
                    w_rearb    = 1'b1;
                    w_arb_last = 1'b1;
                    w_last_nxt = 1'b1;
                end
            end
            default: w_rearb = 1'b1;
        endcase
        if (w_rearb) begin
            if (m0_cyc_i && m1_cyc_i)
                w_state_nxt = w_arb_last ? ST_GRANT0 : ST_GRANT1;
            else if (m0_cyc_i)
                w_state_nxt = ST_GRANT0;
            else if (m1_cyc_i)
                w_state_nxt = ST_GRANT1;
            else
                w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: counts stalled strobe cycles, saturating at TIMEOUT.
    // ------------------------------------------------------------------
    always_comb begin
        w_wcnt_nxt = r_wcnt;
        if (!(w_g0 || w_g1) || (w_state_nxt != r_state) || s_ack_i || w_timeout)
            w_wcnt_nxt = 8'd0;
        else if (w_sel_stb && (r_wcnt != c_timeout))
            w_wcnt_nxt = r_wcnt + 8'd1;
    end

    // ------------------------------------------------------------------
    // Slave-side mux
    // ------------------------------------------------------------------
    always_comb begin
        s_addr_o = 32'd0;
        s_data_o = 32'd0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_sel_o  = 4'd0;
        if (w_g0) begin
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_sel_o  = m0_sel_i;
        end else if (w_g1) begin
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_sel_o  = m1_sel_i;
        end
    end

    assign s_stb_o   = w_sel_stb & ~w_timeout;

    // ------------------------------------------------------------------
    // Master-side return
    // ------------------------------------------------------------------
    assign m0_ack_o  = w_g0 & m0_stb_i & (s_ack_i | w_timeout);
    assign m1_ack_o  = w_g1 & m1_stb_i & (s_ack_i | w_timeout);
    assign m0_data_o = w_g0 ? (w_timeout ? BUS_ERR_DATA : s_data_i) : 32'd0;
    assign m1_data_o = w_g1 ? (w_timeout ? BUS_ERR_DATA : s_data_i) : 32'd0;

    assign gnt_o     = {w_g1, w_g0};
    assign timeout_o = w_timeout;

endmodule
`default_nettype wire
